amo_issue_queue: RTL and testbench
==================================

Name: amo_issue_queue

Overview:
- Parametrised multi-entry atomic-memory-operation buffer between the LSU issue path and the data cache AMO port.
- Queues up to DEPTH AMO requests, each tagged with a result tag.
- Issues each request to the cache only once the LSQ is drained, then returns the cache result, with its tag, to writeback over a valid/ready handshake.
- Supports flush, cache backpressure and optional 32-bit result sign extension.

Parameters:
DEPTH, 2, number of queued AMO entries (>=1)
DATA_W, 64, operand/result data width
PLEN, 56, physical address width
TAG_W, 4, result tag width (destination identifier)
OP_W, 4, AMO opcode width (ariane_pkg::amo_t encoding)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
valid_i  in  1  new AMO request valid
ready_o  out  1  queue can accept (not full, not flushing)
amo_op_i  in  OP_W  AMO opcode
paddr_i  in  PLEN  physical address
data_i  in  DATA_W  store operand
size_i  in  2  access size (2'b10 word, 2'b11 doubleword)
tag_i  in  TAG_W  result tag
flush_i  in  1  discard queued/unreturned AMOs
no_mem_ops_pending_i  in  1  LSQ drained
amo_req_valid_o  out  1  cache request valid
amo_req_op_o  out  OP_W  head opcode
amo_req_addr_o  out  PLEN  head address
amo_req_data_o  out  DATA_W  head operand
amo_req_size_o  out  2  head size
amo_resp_ack_i  in  1  cache done; result valid this cycle
amo_resp_result_i  in  DATA_W  cache result
result_valid_o  out  1  result available
result_tag_o  out  TAG_W  result tag
result_data_o  out  DATA_W  result data
result_ready_i  in  1  writeback accepts result
count_o  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: FIFO empty; count_o=0; FSM in IDLE; amo_req_valid_o=0; result_valid_o=0; result_tag_o/result_data_o=0; ready_o=1 once rst_i deasserts.
- Reset mid-operation: outputs drop immediately (async). Any in-flight cache AMO is abandoned; the cache is reset alongside.
- Storage: circular FIFO with read/write pointers wrapping at DEPTH (DEPTH need not be a power of 2).
  - Push when valid_i && ready_o.
  - ready_o = (count<DEPTH) && !flush_i. No same-cycle push-through when full.
- Head entry: drives amo_req_* combinationally, whether or not a request is valid.
- FSM:
  - IDLE: if count>0 && no_mem_ops_pending_i && !flush_i, go to ISSUE next cycle.
  - ISSUE: amo_req_valid_o=1, held stable until amo_resp_ack_i. On ack: pop head, capture amo_resp_result_i and head tag into result registers, go to RESP.
  - RESP: result_valid_o=1, data/tag stable. On result_ready_i go to IDLE.
- Latency:
  - Push at cycle 0 with LSQ drained: amo_req_valid_o at cycle 2.
  - Ack at cycle N: result_valid_o at N+1.
  - Minimum back-to-back issue spacing is 3 cycles (IDLE/ISSUE/RESP).
- no_mem_ops_pending_i is sampled only in IDLE. Deassertion during ISSUE/RESP has no effect.
- flush_i:
  - Queued entries that have not been issued are cleared (count to 0); a push in the same cycle is ignored.
  - In ISSUE: the request is kept asserted (the cache protocol forbids withdrawal). The ack pops normally, the result is discarded, and the FSM returns to IDLE with result_valid_o kept 0.
  - In RESP: result_valid_o drops next cycle and the FSM goes to IDLE.
  - A pending-drop flag records a flush seen during ISSUE.
- Simultaneous push and pop: count unchanged; pointers both advance.
- count_o is the registered occupancy, including the head entry until it is popped.

Optional Feature:
- AMO_RESULT_SEXT_EN defined: when the captured size is 2'b10, result_data_o = sign-extension of amo_resp_result_i[31:0] to DATA_W.
- Without the macro: result_data_o = amo_resp_result_i unmodified for all sizes.

Test Plan:
- Single AMO: reset, push op=AMOADD, paddr=0x80001000, data=5, tag=3, LSQ drained -> amo_req_valid_o at cycle 2 with matching fields. Ack with result=0x10 -> result_valid_o=1, tag=3, data=0x10; ready=1 -> IDLE, count_o=0.
- Drain gating: push with no_mem_ops_pending_i=0 for 10 cycles -> amo_req_valid_o stays 0. Raise it -> request 1 cycle later.
- Full/backpressure: DEPTH=2, push tags 1, 2 -> ready_o=0, count_o=2. A third valid_i is ignored. Results return in order: tag 1, then tag 2. Hold result_ready_i=0 for 5 cycles -> data stable.
- Flush in ISSUE: 2 entries queued, flush while head is requesting -> count_o=0, req stays high. Ack -> no result_valid_o; FSM in IDLE.
- Reset mid-ISSUE: assert rst_i -> amo_req_valid_o=0 the same cycle; count_o=0.
- Sign extension (macro on): size=2'b10, result=0x00000000_80000000 -> result_data_o=0xFFFFFFFF_80000000. With the macro off -> unchanged.

Source files
------------

// File: rtl/amo_issue_queue.sv
// amo_issue_queue: DEPTH-entry AMO buffer between the LSU and the D$ AMO port; issues once the LSQ drains.
// Rev 1.0. Optional feature macro: AMO_RESULT_SEXT_EN (sign-extend 32-bit results).
`default_nettype none

module amo_issue_queue #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned PLEN   = 56,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned OP_W   = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [OP_W-1:0]            amo_op_i,
  input  logic [PLEN-1:0]            paddr_i,
  input  logic [DATA_W-1:0]          data_i,
  input  logic [1:0]                 size_i,
  input  logic [TAG_W-1:0]           tag_i,
  input  logic                       flush_i,
  input  logic                       no_mem_ops_pending_i,
  output logic                       amo_req_valid_o,
  output logic [OP_W-1:0]            amo_req_op_o,
  output logic [PLEN-1:0]            amo_req_addr_o,
  output logic [DATA_W-1:0]          amo_req_data_o,
  output logic [1:0]                 amo_req_size_o,
  input  logic                       amo_resp_ack_i,
  input  logic [DATA_W-1:0]          amo_resp_result_i,
  output logic                       result_valid_o,
  output logic [TAG_W-1:0]           result_tag_o,
  output logic [DATA_W-1:0]          result_data_o,
  input  logic                       result_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned      CNT_W    = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH-1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [OP_W-1:0]   op_mem   [DEPTH];
  logic [PLEN-1:0]   addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [1:0]        size_mem [DEPTH];
  logic [TAG_W-1:0]  tag_mem  [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d, rd_inc, wr_inc;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              drop_q, drop_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [TAG_W-1:0]  res_tag_q, res_tag_d;
  logic              push, pop;

  assign rd_inc = (rd_q == LAST_PTR) ? '0 : rd_q + 1'b1;
  assign wr_inc = (wr_q == LAST_PTR) ? '0 : wr_q + 1'b1;

  // A flushed-but-in-flight head still occupies its slot until the cache acks it.
  assign ready_o = (({1'b0, count_q} + {{CNT_W{1'b0}}, drop_q}) < DEPTH_C) && !flush_i;
  assign push    = valid_i && ready_o;
  assign pop     = (state_q == S_ISSUE) && amo_resp_ack_i;

  assign amo_req_op_o   = op_mem[rd_q];
  assign amo_req_addr_o = addr_mem[rd_q];
  assign amo_req_data_o = data_mem[rd_q];
  assign amo_req_size_o = size_mem[rd_q];
  assign count_o        = count_q;
  assign result_tag_o   = res_tag_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      op_mem[wr_q]   <= amo_op_i;
      addr_mem[wr_q] <= paddr_i;
      data_mem[wr_q] <= data_i;
      size_mem[wr_q] <= size_i;
      tag_mem[wr_q]  <= tag_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if ((count_q != '0) && no_mem_ops_pending_i && !flush_i) state_d = S_ISSUE;
      S_ISSUE: if (amo_resp_ack_i) state_d = (drop_q || flush_i) ? S_IDLE : S_RESP;
      S_RESP:  if (result_ready_i || flush_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    amo_req_valid_o = (state_q == S_ISSUE);
    result_valid_o  = (state_q == S_RESP);
  end

  always_comb begin
    rd_d       = pop  ? rd_inc : rd_q;
    wr_d       = push ? wr_inc : wr_q;
    count_d    = count_q;
    drop_d     = pop ? 1'b0 : drop_q;
    res_data_d = pop ? amo_resp_result_i : res_data_q;
    res_tag_d  = pop ? tag_mem[rd_q] : res_tag_q;
    if (push && !(pop && !drop_q)) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop && !drop_q) begin
      count_d = count_q - 1'b1;
    end
    // The in-flight head survives a flush until its ack; new pushes land behind it.
    if (flush_i) begin
      count_d = '0;
      wr_d    = rd_d;
      if ((state_q == S_ISSUE) && !amo_resp_ack_i) begin
        wr_d   = rd_inc;
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      drop_q     <= 1'b0;
      res_data_q <= '0;
      res_tag_q  <= '0;
    end else begin
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      res_data_q <= res_data_d;
      res_tag_q  <= res_tag_d;
    end
  end

`ifdef AMO_RESULT_SEXT_EN
  logic [1:0] res_size_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_size_q <= 2'b00;
    end else if (pop) begin
      res_size_q <= size_mem[rd_q];
    end
  end

  assign result_data_o = (res_size_q == 2'b10) ?
                         {{(DATA_W-32){res_data_q[31]}}, res_data_q[31:0]} : res_data_q;
`else
  assign result_data_o = res_data_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_amo_issue_queue.sv
// tb_amo_issue_queue: table-driven vectors plus directed multi-cycle sequences for amo_issue_queue.
// Rev 1.0. Honours AMO_RESULT_SEXT_EN when computing the expected sign-extended result.
`default_nettype none

module tb_amo_issue_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, ready_o;
  logic [3:0]  amo_op_i;
  logic [55:0] paddr_i;
  logic [63:0] data_i;
  logic [1:0]  size_i;
  logic [3:0]  tag_i;
  logic        flush_i, no_mem_ops_pending_i;
  logic        amo_req_valid_o;
  logic [3:0]  amo_req_op_o;
  logic [55:0] amo_req_addr_o;
  logic [63:0] amo_req_data_o;
  logic [1:0]  amo_req_size_o;
  logic        amo_resp_ack_i;
  logic [63:0] amo_resp_result_i;
  logic        result_valid_o;
  logic [3:0]  result_tag_o;
  logic [63:0] result_data_o;
  logic        result_ready_i;
  logic [1:0]  count_o;

  int checks = 0;
  int errors = 0;

  amo_issue_queue #(.DEPTH(2), .DATA_W(64), .PLEN(56), .TAG_W(4), .OP_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .amo_op_i(amo_op_i), .paddr_i(paddr_i), .data_i(data_i), .size_i(size_i), .tag_i(tag_i),
    .flush_i(flush_i), .no_mem_ops_pending_i(no_mem_ops_pending_i),
    .amo_req_valid_o(amo_req_valid_o), .amo_req_op_o(amo_req_op_o),
    .amo_req_addr_o(amo_req_addr_o), .amo_req_data_o(amo_req_data_o),
    .amo_req_size_o(amo_req_size_o), .amo_resp_ack_i(amo_resp_ack_i),
    .amo_resp_result_i(amo_resp_result_i), .result_valid_o(result_valid_o),
    .result_tag_o(result_tag_o), .result_data_o(result_data_o),
    .result_ready_i(result_ready_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [55:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
    logic [3:0]  tag;
    logic        flush, nmp, ack;
    logic [63:0] res;
    logic        rready;
    logic        e_ready, e_reqv, e_resv;
    logic [3:0]  e_tag;
    logic [63:0] e_data;
    logic [55:0] e_addr;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(
    input logic valid, input logic [3:0] op, input logic [55:0] addr, input logic [63:0] data,
    input logic [1:0] size, input logic [3:0] tag, input logic flush, input logic nmp,
    input logic ack, input logic [63:0] res, input logic rready,
    input logic e_ready, input logic e_reqv, input logic e_resv, input logic [3:0] e_tag,
    input logic [63:0] e_data, input logic [55:0] e_addr, input logic [1:0] e_cnt);
    vec_t r;
    r.valid = valid; r.op = op; r.addr = addr; r.data = data; r.size = size; r.tag = tag;
    r.flush = flush; r.nmp = nmp; r.ack = ack; r.res = res; r.rready = rready;
    r.e_ready = e_ready; r.e_reqv = e_reqv; r.e_resv = e_resv; r.e_tag = e_tag;
    r.e_data = e_data; r.e_addr = e_addr; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_req(input logic [3:0] op, input logic [55:0] addr, input logic [63:0] data,
                          input logic [1:0] size, input logic [3:0] tag);
    valid_i = 1'b1; amo_op_i = op; paddr_i = addr; data_i = data; size_i = size; tag_i = tag;
    step();
    valid_i = 1'b0;
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!amo_req_valid_o && n < budget) begin
      step();
      n++;
    end
    chk("wait_req timeout", amo_req_valid_o, 1);
  endtask

  task automatic finish_txn(input logic [63:0] res, input logic [3:0] e_tag, input logic [63:0] e_data);
    amo_resp_ack_i = 1'b1; amo_resp_result_i = res;
    step();
    amo_resp_ack_i = 1'b0;
    chk("txn result_valid", result_valid_o, 1);
    chk("txn result_tag", result_tag_o, e_tag);
    chk("txn result_data", result_data_o, e_data);
    result_ready_i = 1'b1;
    step();
    result_ready_i = 1'b0;
    chk("txn result_valid drop", result_valid_o, 0);
  endtask

  initial begin
    logic [63:0] sext_exp;
    rst_i = 1'b1; valid_i = 0; amo_op_i = 0; paddr_i = 0; data_i = 0; size_i = 0; tag_i = 0;
    flush_i = 0; no_mem_ops_pending_i = 0; amo_resp_ack_i = 0; amo_resp_result_i = 0;
    result_ready_i = 0;
    step(); step();
    chk("reset count", count_o, 0);
    chk("reset req_valid", amo_req_valid_o, 0);
    chk("reset result_valid", result_valid_o, 0);
    chk("reset result_tag", result_tag_o, 0);
    chk("reset result_data", result_data_o, 0);
    rst_i = 1'b0;
    #1;
    chk("reset ready", ready_o, 1);
    step();

    // Single AMO: request two cycles after the push, result one cycle after the ack.
    vecs.push_back(v(1, 4'h4, 56'h80001000, 64'h5, 2'b11, 4'h3, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,           1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,           1, 1, 0, 0, 64'h5, 56'h80001000, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'h10, 0,      1, 1, 0, 0, 64'h5, 56'h80001000, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,           1, 0, 1, 4'h3, 64'h10, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1,           1, 0, 1, 4'h3, 64'h10, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,           1, 0, 0, 0, 0, 0, 0));
    // Fill to DEPTH with the LSQ busy, third push ignored, in-order results with held backpressure.
    vecs.push_back(v(1, 4'h4, 56'h100, 64'h11, 2'b11, 4'h1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 4'h4, 56'h200, 64'h22, 2'b11, 4'h2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, 4'h4, 56'h700, 64'h77, 2'b11, 4'h7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,            0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'hA1, 0,       0, 1, 0, 0, 64'h11, 56'h100, 2));
    for (int k = 0; k < 5; k++)
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,          1, 0, 1, 4'h1, 64'hA1, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1,            1, 0, 1, 4'h1, 64'hA1, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,            1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'hB2, 0,       1, 1, 0, 0, 64'h22, 56'h200, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1,            1, 0, 1, 4'h2, 64'hB2, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,            1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,            1, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      valid_i = vecs[i].valid; amo_op_i = vecs[i].op; paddr_i = vecs[i].addr;
      data_i = vecs[i].data; size_i = vecs[i].size; tag_i = vecs[i].tag;
      flush_i = vecs[i].flush; no_mem_ops_pending_i = vecs[i].nmp;
      amo_resp_ack_i = vecs[i].ack; amo_resp_result_i = vecs[i].res;
      result_ready_i = vecs[i].rready;
      #1;
      chk($sformatf("vec%0d ready", i), ready_o, vecs[i].e_ready);
      chk($sformatf("vec%0d req_valid", i), amo_req_valid_o, vecs[i].e_reqv);
      chk($sformatf("vec%0d result_valid", i), result_valid_o, vecs[i].e_resv);
      chk($sformatf("vec%0d count", i), count_o, vecs[i].e_cnt);
      if (vecs[i].e_reqv) begin
        chk($sformatf("vec%0d req_addr", i), amo_req_addr_o, vecs[i].e_addr);
        chk($sformatf("vec%0d req_data", i), amo_req_data_o, vecs[i].e_data);
      end
      if (vecs[i].e_resv) begin
        chk($sformatf("vec%0d result_tag", i), result_tag_o, vecs[i].e_tag);
        chk($sformatf("vec%0d result_data", i), result_data_o, vecs[i].e_data);
      end
      step();
    end
    valid_i = 0; amo_resp_ack_i = 0; result_ready_i = 0;

    // Drain gating: nothing issues while the LSQ is busy; issue one cycle after it drains.
    no_mem_ops_pending_i = 1'b0;
    push_req(4'h3, 56'h4000, 64'hAB, 2'b11, 4'h6);
    for (int k = 0; k < 10; k++) begin
      chk("gated req_valid", amo_req_valid_o, 0);
      step();
    end
    no_mem_ops_pending_i = 1'b1;
    step();
    chk("drained req_valid", amo_req_valid_o, 1);
    chk("drained req_op", amo_req_op_o, 4'h3);
    chk("drained req_size", amo_req_size_o, 2'b11);
    finish_txn(64'h55, 4'h6, 64'h55);

    // Flush while the head is requesting: request stays up, result dropped, new push still works.
    no_mem_ops_pending_i = 1'b0;
    push_req(4'h4, 56'h300, 64'h33, 2'b11, 4'h5);
    push_req(4'h4, 56'h400, 64'h44, 2'b11, 4'h6);
    no_mem_ops_pending_i = 1'b1;
    wait_req(4);
    flush_i = 1'b1;
    #1;
    chk("flush ready", ready_o, 0);
    step();
    flush_i = 1'b0;
    chk("flush count", count_o, 0);
    chk("flush req held", amo_req_valid_o, 1);
    chk("flush req addr", amo_req_addr_o, 56'h300);
    valid_i = 1'b1; amo_op_i = 4'h4; paddr_i = 56'h500; data_i = 64'h99; size_i = 2'b11; tag_i = 4'h9;
    #1;
    chk("post-flush ready", ready_o, 1);
    step();
    valid_i = 1'b0;
    chk("post-flush count", count_o, 1);
    amo_resp_ack_i = 1'b1; amo_resp_result_i = 64'hDEAD;
    step();
    amo_resp_ack_i = 1'b0;
    chk("dropped result_valid", result_valid_o, 0);
    chk("dropped req_valid", amo_req_valid_o, 0);
    chk("dropped count", count_o, 1);
    wait_req(4);
    chk("next req addr", amo_req_addr_o, 56'h500);
    chk("next req data", amo_req_data_o, 64'h99);
    finish_txn(64'h77, 4'h9, 64'h77);
    chk("empty count", count_o, 0);

    // Asynchronous reset in the middle of an issue.
    push_req(4'h4, 56'h600, 64'h66, 2'b11, 4'h1);
    wait_req(4);
    #2;
    rst_i = 1'b1;
    #1;
    chk("async rst req_valid", amo_req_valid_o, 0);
    chk("async rst count", count_o, 0);
    step();
    rst_i = 1'b0;
    step();
    chk("after rst req_valid", amo_req_valid_o, 0);
    chk("after rst count", count_o, 0);

    // Word-sized result sign extension.
`ifdef AMO_RESULT_SEXT_EN
    sext_exp = 64'hFFFF_FFFF_8000_0000;
`else
    sext_exp = 64'h0000_0000_8000_0000;
`endif
    push_req(4'h4, 56'h800, 64'h1, 2'b10, 4'h4);
    wait_req(4);
    chk("word req_size", amo_req_size_o, 2'b10);
    finish_txn(64'h0000_0000_8000_0000, 4'h4, sext_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
